// File: rtl/gx4000_pkg.sv
// Shared constants for the Plus-ASIC unlock path: ACID byte sequence, matcher states, RMR2 fields.
package gx4000_pkg;

  typedef enum logic [1:0] {SYNC_NZ, SYNC_Z, MATCH, KEY} acid_fsm_t;

  localparam logic [2:0] RMR2_TAG = 3'b101;
  localparam logic [1:0] PAGE_LOC = 2'b11;

  // Entries 0..16 are the real ACID sequence; the tail only matters for longer SEQ_LEN builds.
  localparam logic [7:0] ACID_SEQ [0:31] = '{
    8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4,
    8'h62, 8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD,
    8'hEE, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h96, 8'h69, 8'h1E,
    8'hE1, 8'h4B, 8'hB4, 8'h2D, 8'hD2, 8'h87, 8'h78, 8'hF0
  };

endpackage

// File: rtl/gx4000_unlock_matcher.sv
// Write-edge detect and ACID sequence matcher; state and unlock flag update the cycle after a CRTC write event.
// No backpressure: it passively snoops the I/O bus and never stalls the CPU.
module gx4000_unlock_matcher
  import gx4000_pkg::*;
#(
  parameter int         SEQ_LEN      = 17,
  parameter logic [7:0] CRTC_HI      = 8'hBC,
  parameter logic [7:0] UNLOCK_KEY   = 8'hEE,
  parameter bit         ALLOW_RELOCK = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       plus_mode,
  input  logic [7:0] cpu_addr_hi,
  input  logic [7:0] cpu_dout,
  input  logic       io_wr,
  output logic       wr_evt,
  output logic       asic_unlocked,
  output logic       unlock_pulse,
  output logic [4:0] seq_index
);

  localparam int IDX_W = $clog2(SEQ_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_MATCH = IDX_W'(SEQ_LEN - 3);
  // With three or fewer bytes the sync pair is followed directly by the key.
  localparam acid_fsm_t AFTER_SYNC = (SEQ_LEN <= 3) ? KEY : MATCH;

  acid_fsm_t        state;
  logic [IDX_W-1:0] idx;
  logic             io_wr_q;
  logic             prev_nz;
  logic             crtc_evt;
  logic             byte_nz;
  logic [4:0]       exp_pos;

  assign wr_evt    = io_wr & ~io_wr_q;
  assign crtc_evt  = wr_evt && (cpu_addr_hi == CRTC_HI);
  assign byte_nz   = (cpu_dout != 8'h00);
  assign exp_pos   = 5'(idx) + 5'd1;
  assign seq_index = 5'(idx);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      io_wr_q       <= 1'b0;
      state         <= SYNC_NZ;
      idx           <= '0;
      prev_nz       <= 1'b0;
      asic_unlocked <= 1'b0;
      unlock_pulse  <= 1'b0;
    end else begin
      io_wr_q      <= io_wr;
      unlock_pulse <= 1'b0;
      if (!plus_mode) begin
        state         <= SYNC_NZ;
        idx           <= '0;
        prev_nz       <= 1'b0;
        asic_unlocked <= 1'b0;
      end else if (crtc_evt) begin
        prev_nz <= byte_nz;
        case (state)
          SYNC_NZ: if (byte_nz) state <= SYNC_Z;
          SYNC_Z: begin
            if (!byte_nz) begin
              state <= AFTER_SYNC;
              idx   <= IDX_W'(1);
            end
          end
          MATCH: begin
            if (cpu_dout == ACID_SEQ[exp_pos]) begin
              idx <= idx + 1'b1;
              if (idx == LAST_MATCH) state <= KEY;
            end else if (byte_nz) begin
              state <= SYNC_Z;
              idx   <= '0;
            end else if (prev_nz) begin
              // A zero after a non-zero byte is itself a valid sync pair.
              idx <= IDX_W'(1);
            end else begin
              state <= SYNC_NZ;
              idx   <= '0;
            end
          end
          KEY: begin
            state <= SYNC_NZ;
            idx   <= '0;
            if (cpu_dout == UNLOCK_KEY) begin
              asic_unlocked <= 1'b1;
              unlock_pulse  <= ~asic_unlocked;
            end else if (ALLOW_RELOCK) begin
              asic_unlocked <= 1'b0;
            end
          end
          default: begin
            state <= SYNC_NZ;
            idx   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gx4000_asic_unlock_ctrl.sv
// Plus-ASIC lock/unlock controller: sequence matcher plus unlock-gated RMR2 latch; outputs update one cycle after a write event.
// No backpressure: pure bus snooper, every write strobe is observed exactly once.
module gx4000_asic_unlock_ctrl
  import gx4000_pkg::*;
#(
  parameter int         SEQ_LEN      = 17,
  parameter logic [7:0] CRTC_HI      = 8'hBC,
  parameter logic [7:0] GA_HI        = 8'h7F,
  parameter logic [7:0] UNLOCK_KEY   = 8'hEE,
  parameter bit         ALLOW_RELOCK = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        io_wr,
  output logic        asic_unlocked,
  output logic        asic_page_en,
  output logic [2:0]  rmr2_rom_sel,
  output logic [1:0]  rmr2_loc,
  output logic        unlock_pulse,
  output logic [4:0]  seq_index
);

  logic wr_evt;
  logic rmr2_hit;
  logic unused_addr_lo;

  assign unused_addr_lo = ^cpu_addr[7:0];

  gx4000_unlock_matcher #(
    .SEQ_LEN      (SEQ_LEN),
    .CRTC_HI      (CRTC_HI),
    .UNLOCK_KEY   (UNLOCK_KEY),
    .ALLOW_RELOCK (ALLOW_RELOCK)
  ) u_matcher (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .plus_mode     (plus_mode),
    .cpu_addr_hi   (cpu_addr[15:8]),
    .cpu_dout      (cpu_dout),
    .io_wr         (io_wr),
    .wr_evt        (wr_evt),
    .asic_unlocked (asic_unlocked),
    .unlock_pulse  (unlock_pulse),
    .seq_index     (seq_index)
  );

  assign rmr2_hit = wr_evt && (cpu_addr[15:8] == GA_HI) && (cpu_dout[7:5] == RMR2_TAG);

  // RMR2 fields survive a relock; only reset or leaving Plus mode clears them.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      rmr2_loc     <= 2'b00;
      rmr2_rom_sel <= 3'b000;
    end else if (!plus_mode) begin
      rmr2_loc     <= 2'b00;
      rmr2_rom_sel <= 3'b000;
    end else if (rmr2_hit && asic_unlocked) begin
      rmr2_loc     <= cpu_dout[4:3];
      rmr2_rom_sel <= cpu_dout[2:0];
    end
  end

  assign asic_page_en = asic_unlocked && (rmr2_loc == PAGE_LOC);

endmodule
